mult8m12_rr_sched: RTL and testbench

Round-robin scheduler that shares one signed 8×12 combinational multiplier (`lib_mult8M12`) among `NREQ` requesters. It accepts one operand pair per cycle over per-requester valid/ready handshakes and registers operands and product in a two-stage pipeline. Each product is returned on a single result port, tagged with the requester index, under downstream backpressure. It sits between the filter/accumulator clients and the shared multiplier resource.

---
 rtl/mult8m12_rr_sched_pkg.sv | 22 ++
 rtl/mult8m12_rr_sched_if.sv | 24 ++
 rtl/mult8m12_rr_sched_mult.sv | 15 +
 rtl/mult8m12_rr_sched.sv | 118 +++++++++++
 tb/tb_mult8m12_rr_sched.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mult8m12_rr_sched_pkg.sv
// Shared constants, stage record and round-robin helper for the multiplier scheduler.
package mult_sched_pkg;

  localparam int Na   = 8;
  localparam int Nb   = 12;
  localparam int Nx   = Na + Nb;
  localparam int ID_W = 3;

  typedef struct packed {
    logic                   valid;
    logic [ID_W-1:0]        id;
    logic signed [Na-1:0]   a;
    logic signed [Nb-1:0]   b;
  } stage_t;

  // Priority moves to the requester just after the one that won.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] cur, input int nreq);
    if (int'(cur) + 1 >= nreq) return '0;
    return cur + 3'd1;
  endfunction

endpackage

// File: rtl/mult8m12_rr_sched_if.sv
// Requester and result handshake bundle of the shared-multiplier scheduler.
interface mult8m12_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int Na   = 8,
  parameter int Nb   = 12
);
  localparam int Nx  = Na + Nb;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*Na-1:0] req_a;
  logic [NREQ*Nb-1:0] req_b;
  logic               res_valid;
  logic               res_ready;
  logic [IDW-1:0]     res_id;
  logic [Nx-1:0]      res_x;
  logic               busy;

  modport slave  (input  req_valid, req_a, req_b, res_ready,
                  output req_ready, res_valid, res_id, res_x, busy);
  modport master (output req_valid, req_a, req_b, res_ready,
                  input  req_ready, res_valid, res_id, res_x, busy);
endinterface

// File: rtl/mult8m12_rr_sched_mult.sv
// Signed 8x12 combinational multiplier, full-width product.
module lib_mult8M12
  import mult_sched_pkg::*;
(
  input  logic signed [Na-1:0] a_i,
  input  logic signed [Nb-1:0] b_i,
  output logic signed [Nx-1:0] x_o
);
  logic signed [Nx-1:0] a_ext;
  logic signed [Nx-1:0] b_ext;

  assign a_ext = {{Nb{a_i[Na-1]}}, a_i};
  assign b_ext = {{Na{b_i[Nb-1]}}, b_i};
  assign x_o   = a_ext * b_ext;
endmodule

// File: rtl/mult8m12_rr_sched.sv
// Round-robin arbiter feeding one shared signed multiplier through a two-stage pipeline.
module mult8m12_rr_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  mult8m12_rr_sched_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  stage_t                st_p1_q, st_p1_d;
  logic [ID_W-1:0]       rr_q, rr_d;
  logic                  res_vld_p2_q, res_vld_p2_d;
  logic [IDW-1:0]        res_id_p2_q, res_id_p2_d;
  logic signed [Nx-1:0]  res_x_p2_q, res_x_p2_d;
  logic signed [Nx-1:0]  prod_p1;

  logic                  s1_adv, s2_adv, win_vld, accept;
  logic [ID_W-1:0]       win;
  logic [3:0]            sum;
  logic [7:0]            vld8;
  logic [NREQ-1:0]       ready;
  logic signed [Na-1:0]  a_sel;
  logic signed [Nb-1:0]  b_sel;
  logic                  unused_id_p1;

  assign s2_adv = !res_vld_p2_q || bus.res_ready;
  assign s1_adv = !st_p1_q.valid || s2_adv;
  assign vld8   = 8'(bus.req_valid);
  assign accept = win_vld && s1_adv && !rst;

  // Scan from rr_q upward with wrap; first asserted valid wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_q} + 4'(k);
      if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
      if (!win_vld && vld8[sum[2:0]]) begin
        win     = sum[2:0];
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ready = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == win) begin
        ready[i] = accept;
        a_sel    = bus.req_a[i*Na +: Na];
        b_sel    = bus.req_b[i*Nb +: Nb];
      end
    end
  end

  // Stage 1: captured operands, held while stage 2 is stalled
  always_comb begin
    st_p1_d = st_p1_q;
    rr_d    = accept ? rr_next(win, NREQ) : rr_q;
    if (s1_adv) begin
      st_p1_d.valid = accept;
      if (accept) begin
        st_p1_d.id = win;
        st_p1_d.a  = a_sel;
        st_p1_d.b  = b_sel;
      end
    end
  end

  lib_mult8M12 u_mult (
    .a_i (st_p1_q.a),
    .b_i (st_p1_q.b),
    .x_o (prod_p1)
  );

  // Stage 2: output register; data only reloads on a real result so it stays stable
  always_comb begin
    res_vld_p2_d = res_vld_p2_q;
    res_id_p2_d  = res_id_p2_q;
    res_x_p2_d   = res_x_p2_q;
    if (s2_adv) begin
      res_vld_p2_d = st_p1_q.valid;
      if (st_p1_q.valid) begin
        res_id_p2_d = st_p1_q.id[IDW-1:0];
        res_x_p2_d  = prod_p1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_p1_q      <= '0;
      rr_q         <= '0;
      res_vld_p2_q <= 1'b0;
      res_id_p2_q  <= '0;
      res_x_p2_q   <= '0;
    end else begin
      st_p1_q      <= st_p1_d;
      rr_q         <= rr_d;
      res_vld_p2_q <= res_vld_p2_d;
      res_id_p2_q  <= res_id_p2_d;
      res_x_p2_q   <= res_x_p2_d;
    end
  end

  assign unused_id_p1  = ^st_p1_q.id;
  assign bus.req_ready = ready;
  assign bus.res_valid = res_vld_p2_q;
  assign bus.res_id    = res_id_p2_q;
  assign bus.res_x     = res_x_p2_q;
  assign bus.busy      = st_p1_q.valid | res_vld_p2_q;
endmodule

// File: tb/tb_mult8m12_rr_sched.sv
// Directed bench for the round-robin multiplier scheduler with a result scoreboard.
module tb_mult8m12_rr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mult8m12_rr_sched_if #(.NREQ(4), .Na(8), .Nb(12)) bus ();

  mult8m12_rr_sched #(.NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [19:0] x;
  } exp_t;

  exp_t                q[$];
  logic signed [7:0]   a_tab[4];
  logic signed [11:0]  b_tab[4];
  int                  total = 0;
  int                  bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] prod(input int i);
    int p;
    p = int'(a_tab[i]) * int'(b_tab[i]);
    return p[19:0];
  endfunction

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*8 +: 8]   = a_tab[i];
      bus.req_b[i*12 +: 12] = b_tab[i];
    end
  endtask

  // Entered at posedge+1: drive, check, score, then advance one clock.
  task automatic cyc(input logic [3:0] vmask, input logic rr, input logic [3:0] exp_rdy);
    exp_t e;
    load_ops();
    bus.req_valid = vmask;
    bus.res_ready = rr;
    #1;
    chk_eq("req_ready", bus.req_ready, exp_rdy);
    if (bus.res_valid && rr) begin
      if (q.size() == 0) chk_eq("res_unexpected", bus.res_valid, 0);
      else begin
        e = q.pop_front();
        chk_eq("sb_id", bus.res_id, e.id);
        chk_eq("sb_x", bus.res_x, e.x);
      end
    end
    for (int i = 0; i < 4; i++)
      if (exp_rdy[i]) q.push_back('{id: i, x: prod(i)});
    @(posedge clk);
    #1;
  endtask

  task automatic one_shot(input int id, input logic signed [7:0] a, input logic signed [11:0] b,
                          input logic [19:0] xexp);
    a_tab[id] = a;
    b_tab[id] = b;
    cyc(4'(1 << id), 1'b1, 4'(1 << id));
    chk_eq("lat_vld_early", bus.res_valid, 0);
    chk_eq("lat_busy", bus.busy, 1);
    cyc(4'b0000, 1'b1, 4'b0000);
    chk_eq("lat_vld", bus.res_valid, 1);
    chk_eq("lat_id", bus.res_id, id);
    chk_eq("lat_x", bus.res_x, xexp);
    cyc(4'b0000, 1'b1, 4'b0000);
    chk_eq("drain_vld", bus.res_valid, 0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_tab[i] = '0;
      b_tab[i] = '0;
    end
    load_ops();
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_vld", bus.res_valid, 0);
    chk_eq("rst_id", bus.res_id, 0);
    chk_eq("rst_x", bus.res_x, 0);
    chk_eq("rst_busy", bus.busy, 0);
    chk_eq("rst_ready", bus.req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single request and extremes (pointer ends at 0 after req 3)
    one_shot(2, 8'sd3, -12'sd5, 20'hFFFF1);
    one_shot(3, -8'sd128, -12'sd2048, 20'h40000);
    one_shot(3, 8'sd127, -12'sd2048, 20'hC0800);
    one_shot(3, 8'sd0, 12'sd2047, 20'h00000);

    // Pointer hold: req 3 alone, then 1 and 3 together
    one_shot(3, 8'sd5, 12'sd7, 20'h00023);
    a_tab[1] = -8'sd9; b_tab[1] = 12'sd11;
    cyc(4'b1010, 1'b1, 4'b0010);
    cyc(4'b1000, 1'b1, 4'b1000);
    repeat (3) cyc(4'b0000, 1'b1, 4'b0000);
    chk_eq("hold_q_empty", q.size(), 0);

    // Fairness and full throughput
    a_tab[0] = 8'sd1;  b_tab[0] = 12'sd100;
    a_tab[1] = -8'sd2; b_tab[1] = -12'sd200;
    a_tab[2] = 8'sd3;  b_tab[2] = -12'sd300;
    a_tab[3] = -8'sd4; b_tab[3] = 12'sd400;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) chk_eq("tput_vld", bus.res_valid, 1);
      cyc(4'b1111, 1'b1, 4'(1 << (c % 4)));
    end
    repeat (3) cyc(4'b0000, 1'b1, 4'b0000);
    chk_eq("fair_q_empty", q.size(), 0);

    // Backpressure with both stages full
    cyc(4'b0111, 1'b1, 4'b0001);
    cyc(4'b0111, 1'b1, 4'b0010);
    cyc(4'b0111, 1'b1, 4'b0100);
    for (int s = 0; s < 5; s++) begin
      bus.req_valid = 4'b0111;
      bus.res_ready = 1'b0;
      #1;
      chk_eq("bp_ready", bus.req_ready, 0);
      chk_eq("bp_vld", bus.res_valid, 1);
      chk_eq("bp_id", bus.res_id, 1);
      chk_eq("bp_x", bus.res_x, prod(1));
      chk_eq("bp_busy", bus.busy, 1);
      @(posedge clk);
      #1;
    end
    repeat (3) cyc(4'b0000, 1'b1, 4'b0000);
    chk_eq("bp_q_empty", q.size(), 0);
    chk_eq("bp_drained", bus.res_valid, 0);

    // Reset mid-flight (pointer is 3 here)
    cyc(4'b1111, 1'b1, 4'b1000);
    cyc(4'b1111, 1'b1, 4'b0001);
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b0;
    #1;
    chk_eq("mid_full_busy", bus.busy, 1);
    chk_eq("mid_full_ready", bus.req_ready, 0);
    #1;
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_vld", bus.res_valid, 0);
    chk_eq("mid_rst_id", bus.res_id, 0);
    chk_eq("mid_rst_x", bus.res_x, 0);
    chk_eq("mid_rst_busy", bus.busy, 0);
    chk_eq("mid_rst_ready", bus.req_ready, 0);
    q.delete();
    bus.req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk_eq("post_rst_quiet", bus.res_valid, 0);
      cyc(4'b0000, 1'b1, 4'b0000);
    end
    cyc(4'b1111, 1'b1, 4'b0001);
    cyc(4'b0000, 1'b1, 4'b0000);
    chk_eq("post_rst_vld", bus.res_valid, 1);
    cyc(4'b0000, 1'b1, 4'b0000);
    chk_eq("post_rst_q_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
